ddr3_app_responder: RTL and testbench



---
 rtl/ddr3_resp_pkg.sv | 23 ++
 rtl/ddr3_resp_ram.sv | 28 ++
 rtl/ddr3_app_responder.sv | 151 +++++++++++++++
 tb/tb_ddr3_app_responder.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr3_resp_pkg.sv
// Shared definitions for the DDR3 app-interface responder: command codes,
// bus widths, FSM state encoding and the stall LFSR step function.
package ddr3_resp_pkg;

  localparam logic [2:0] CMD_WRITE = 3'd0;
  localparam logic [2:0] CMD_READ  = 3'd1;

  localparam int DATA_W     = 256;
  localparam int ADDR_W     = 29;
  localparam int BURST_STEP = 8;

  typedef enum logic [2:0] {
    ST_CALIB   = 3'b001,
    ST_RUN     = 3'b010,
    ST_REFRESH = 3'b100
  } resp_state_t;

  // Fibonacci LFSR, taps 16/14/13/11 (maximal length for 16 bits).
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

endpackage

// File: rtl/ddr3_resp_ram.sv
// Simple dual-port backing RAM: one write port, one registered read port.
// Read-during-write to the same word returns the old contents.
module ddr3_resp_ram
  import ddr3_resp_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic              ui_clk,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge ui_clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  always_ff @(posedge ui_clk) begin
    if (rd_en) rd_data <= mem[rd_idx];
  end

endmodule

// File: rtl/ddr3_app_responder.sv
// Memory-controller stand-in for the DDR3 app interface: emulates calibration,
// refresh back-pressure, write-data stalls and fixed read latency over an on-chip RAM.
module ddr3_app_responder
  import ddr3_resp_pkg::*;
#(
  parameter int          DEPTH          = 1024,
  parameter int          CALIB_CYCLES   = 200,
  parameter int          RD_LATENCY     = 8,
  parameter int          REFRESH_PERIOD = 1000,
  parameter int          REFRESH_CYCLES = 20,
  parameter int          STALL_EN       = 1,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic              ui_clk,
  input  logic              rst_n,
  output logic              init_calib_complete,
  output logic              app_rdy,
  output logic              app_wdf_rdy,
  input  logic              app_en,
  input  logic [2:0]        app_cmd,
  input  logic [ADDR_W-1:0] app_addr,
  input  logic              app_wdf_wren,
  input  logic              app_wdf_end,
  input  logic [DATA_W-1:0] app_wdf_data,
  output logic              app_rd_data_valid,
  output logic [DATA_W-1:0] app_rd_data,
  output logic              proto_err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int LSB   = $clog2(BURST_STEP);

  resp_state_t state, state_nxt;
  logic [31:0] cnt, cnt_nxt;
  logic [15:0] lfsr, lfsr_nxt;
  logic        run_nxt;
  logic        stall_bit;

  logic        cmd_fire, is_wr, is_rd;
  logic        end_bad, wren_bad, data_ok;
  logic        wr_commit, rd_accept, misaligned, any_err;
  logic [IDX_W-1:0] ram_idx;
  logic [DATA_W-1:0] ram_rd_data;

  logic [RD_LATENCY-1:0] vld_sr;
  logic [DATA_W-1:0]     dsr [1:RD_LATENCY-1];

  logic unused_addr_hi;
  assign unused_addr_hi = ^app_addr[ADDR_W-1:LSB+IDX_W];

  // One shared counter times calibration, the refresh interval and the refresh stall.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 32'd1;
    case (state)
      ST_CALIB: begin
        if (cnt >= 32'(CALIB_CYCLES - 1)) begin
          state_nxt = ST_RUN;
          cnt_nxt   = '0;
        end
      end
      ST_RUN: begin
        if (REFRESH_PERIOD == 0) begin
          cnt_nxt = '0;
        end else if (cnt >= 32'(REFRESH_PERIOD - 1)) begin
          state_nxt = ST_REFRESH;
          cnt_nxt   = '0;
        end
      end
      ST_REFRESH: begin
        if (cnt >= 32'(REFRESH_CYCLES - 1)) begin
          state_nxt = ST_RUN;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ST_CALIB;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign run_nxt   = (state_nxt == ST_RUN);
  assign lfsr_nxt  = (state == ST_RUN) ? lfsr_step(lfsr) : lfsr;
  assign stall_bit = (STALL_EN != 0) && lfsr_nxt[0];

  assign cmd_fire   = app_en && app_rdy;
  assign is_wr      = (app_cmd == CMD_WRITE);
  assign is_rd      = (app_cmd == CMD_READ);
  assign end_bad    = (app_wdf_end != app_wdf_wren);
  assign wren_bad   = app_wdf_wren && !app_wdf_rdy;
  assign data_ok    = app_wdf_wren && app_wdf_rdy && !end_bad;
  assign wr_commit  = cmd_fire && is_wr && data_ok;
  assign rd_accept  = cmd_fire && is_rd;
  assign misaligned = cmd_fire && (is_wr || is_rd) && (app_addr[LSB-1:0] != '0);
  assign ram_idx    = app_addr[LSB +: IDX_W];

  // A write command is dropped unless its data beat is taken in the same cycle.
  assign any_err = (cmd_fire && !is_wr && !is_rd)
                 || end_bad
                 || wren_bad
                 || (cmd_fire && is_wr && !data_ok)
                 || misaligned;

  always_ff @(posedge ui_clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= ST_CALIB;
      cnt                 <= '0;
      lfsr                <= LFSR_SEED;
      init_calib_complete <= 1'b0;
      app_rdy             <= 1'b0;
      app_wdf_rdy         <= 1'b0;
      proto_err           <= 1'b0;
      vld_sr              <= '0;
      app_rd_data_valid   <= 1'b0;
      app_rd_data         <= '0;
    end else begin
      state               <= state_nxt;
      cnt                 <= cnt_nxt;
      lfsr                <= lfsr_nxt;
      init_calib_complete <= init_calib_complete || run_nxt;
      app_rdy             <= run_nxt;
      app_wdf_rdy         <= run_nxt && !stall_bit;
      proto_err           <= proto_err || any_err;
      vld_sr              <= {vld_sr[RD_LATENCY-2:0], rd_accept};
      app_rd_data_valid   <= vld_sr[RD_LATENCY-1];
      if (vld_sr[RD_LATENCY-1]) app_rd_data <= dsr[RD_LATENCY-1];
    end
  end

  // Data delay line needs no reset: the valid shift register qualifies it,
  // and it keeps draining through refresh.
  always_ff @(posedge ui_clk) begin
    dsr[1] <= ram_rd_data;
    for (int i = 2; i < RD_LATENCY; i++) dsr[i] <= dsr[i-1];
  end

  ddr3_resp_ram #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_ram (
    .ui_clk  (ui_clk),
    .wr_en   (wr_commit),
    .wr_idx  (ram_idx),
    .wr_data (app_wdf_data),
    .rd_en   (rd_accept),
    .rd_idx  (ram_idx),
    .rd_data (ram_rd_data)
  );

endmodule

// File: tb/tb_ddr3_app_responder.sv
// Directed bench for ddr3_app_responder: vector table for write/read traffic,
// hand sequences for calibration, refresh, protocol errors and mid-read reset.
module tb_ddr3_app_responder;

  localparam int RD_LAT = 8;
  localparam int NVEC   = 34;

  logic         ui_clk;
  logic         rst_n;
  logic         init_calib_complete;
  logic         app_rdy;
  logic         app_wdf_rdy;
  logic         app_en;
  logic [2:0]   app_cmd;
  logic [28:0]  app_addr;
  logic         app_wdf_wren;
  logic         app_wdf_end;
  logic [255:0] app_wdf_data;
  logic         app_rd_data_valid;
  logic [255:0] app_rd_data;
  logic         proto_err;

  typedef struct {
    logic         is_wr;
    logic [28:0]  addr;
    logic [255:0] wdata;
    logic [255:0] exp;
  } vec_t;

  typedef struct {
    logic [255:0] data;
    int           due;
  } sb_entry_t;

  vec_t      vecs [NVEC];
  sb_entry_t sb [$];
  sb_entry_t mon_e;
  int        checks = 0;
  int        errors = 0;
  int        cyc = 0;

  ddr3_app_responder #(
    .DEPTH          (1024),
    .CALIB_CYCLES   (200),
    .RD_LATENCY     (RD_LAT),
    .REFRESH_PERIOD (100),
    .REFRESH_CYCLES (20),
    .STALL_EN       (1),
    .LFSR_SEED      (16'hACE1)
  ) dut (
    .ui_clk              (ui_clk),
    .rst_n               (rst_n),
    .init_calib_complete (init_calib_complete),
    .app_rdy             (app_rdy),
    .app_wdf_rdy         (app_wdf_rdy),
    .app_en              (app_en),
    .app_cmd             (app_cmd),
    .app_addr            (app_addr),
    .app_wdf_wren        (app_wdf_wren),
    .app_wdf_end         (app_wdf_end),
    .app_wdf_data        (app_wdf_data),
    .app_rd_data_valid   (app_rd_data_valid),
    .app_rd_data         (app_rd_data),
    .proto_err           (proto_err)
  );

  initial ui_clk = 1'b0;
  always #5 ui_clk = ~ui_clk;

  always @(posedge ui_clk) cyc <= cyc + 1;

  function automatic logic [255:0] pat(input int i);
    return {8{32'hC0DE_0000 | 32'(i)}};
  endfunction

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic idleInputs();
    app_en       = 1'b0;
    app_cmd      = 3'd0;
    app_addr     = '0;
    app_wdf_wren = 1'b0;
    app_wdf_end  = 1'b0;
    app_wdf_data = '0;
  endtask

  // Waits at negedges until the needed ready signals are high; false on timeout.
  task automatic waitReady(input logic need_wdf, output bit ok);
    int waited = 0;
    @(negedge ui_clk);
    while (!(app_rdy && (!need_wdf || app_wdf_rdy)) && waited < 500) begin
      @(negedge ui_clk);
      waited++;
    end
    ok = (waited < 500);
    if (!ok) checkOutput("ready_timeout", 256'(waited), 256'(0));
  endtask

  // Drives a read for the coming edge and books its expected return.
  task automatic driveRead(input logic [28:0] addr, input logic [255:0] exp);
    sb_entry_t e;
    app_en   = 1'b1;
    app_cmd  = 3'd1;
    app_addr = addr;
    e.data   = exp;
    e.due    = cyc + 1 + RD_LAT;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input vec_t v);
    bit ok;
    waitReady(v.is_wr, ok);
    if (!ok) return;
    if (v.is_wr) begin
      app_en       = 1'b1;
      app_cmd      = 3'd0;
      app_addr     = v.addr;
      app_wdf_wren = 1'b1;
      app_wdf_end  = 1'b1;
      app_wdf_data = v.wdata;
    end else begin
      driveRead(v.addr, v.exp);
    end
    @(posedge ui_clk);
    #1 idleInputs();
  endtask

  // Scoreboard: every valid must match the oldest booked read, on its due cycle.
  always @(negedge ui_clk) begin
    if (app_rd_data_valid) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_valid", 256'(app_rd_data_valid), 256'(0));
      end else begin
        mon_e = sb.pop_front();
        checkOutput("rd_latency", 256'(cyc), 256'(mon_e.due));
        checkOutput("rd_data", app_rd_data, mon_e.data);
      end
    end
    if (sb.size() > 0 && sb[0].due < cyc) begin
      checkOutput("rd_missing", 256'(cyc), 256'(sb[0].due));
      void'(sb.pop_front());
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit ok;
    int n, hi, lo;
    logic early;
    vec_t v;

    for (int i = 0; i < 16; i++) begin
      vecs[i]      = '{1'b1, 29'(i * 8), pat(i), '0};
      vecs[16 + i] = '{1'b0, 29'(i * 8), '0, pat(i)};
    end
    vecs[32] = '{1'b1, 29'd8192, {32{8'hA5}}, '0};
    vecs[33] = '{1'b0, 29'd0, '0, {32{8'hA5}}};

    rst_n = 1'b0;
    idleInputs();
    repeat (3) @(negedge ui_clk);
    checkOutput("rst_calib", 256'(init_calib_complete), 256'(0));
    checkOutput("rst_app_rdy", 256'(app_rdy), 256'(0));
    checkOutput("rst_wdf_rdy", 256'(app_wdf_rdy), 256'(0));
    checkOutput("rst_valid", 256'(app_rd_data_valid), 256'(0));
    checkOutput("rst_rd_data", app_rd_data, 256'(0));
    checkOutput("rst_proto_err", 256'(proto_err), 256'(0));

    // Calibration: nothing may rise before the 200th edge.
    rst_n = 1'b1;
    early = 1'b0;
    for (int k = 1; k < 200; k++) begin
      @(negedge ui_clk);
      early = early | init_calib_complete | app_rdy | app_wdf_rdy | app_rd_data_valid | proto_err;
    end
    checkOutput("calib_early", 256'(early), 256'(0));
    @(negedge ui_clk);
    checkOutput("calib_done", 256'(init_calib_complete), 256'(1));
    checkOutput("calib_app_rdy", 256'(app_rdy), 256'(1));

    for (int i = 0; i < NVEC; i++) applyStimulus(vecs[i]);
    repeat (RD_LAT + 4) @(negedge ui_clk);
    checkOutput("table_drain", 256'(sb.size()), 256'(0));
    checkOutput("stall_no_err", 256'(proto_err), 256'(0));

    // Refresh: measure one window, then launch 4 reads in the last ready cycles.
    n = 0;
    while (app_rdy && n < 300) begin @(negedge ui_clk); n++; end
    n = 0;
    while (!app_rdy && n < 300) begin @(negedge ui_clk); n++; end
    hi = 0;
    while (app_rdy && hi < 300) begin @(negedge ui_clk); hi++; end
    checkOutput("refresh_run_len", 256'(hi), 256'(100));
    lo = 0;
    while (!app_rdy && lo < 300) begin @(negedge ui_clk); lo++; end
    checkOutput("refresh_stall_len", 256'(lo), 256'(20));
    checkOutput("refresh_calib_held", 256'(init_calib_complete), 256'(1));
    repeat (96) @(negedge ui_clk);
    for (int j = 0; j < 4; j++) begin
      driveRead(29'((3 + j) * 8), pat(3 + j));
      @(negedge ui_clk);
    end
    idleInputs();
    checkOutput("refresh_entered", 256'(app_rdy), 256'(0));
    repeat (RD_LAT + 4) @(negedge ui_clk);
    checkOutput("refresh_drain", 256'(sb.size()), 256'(0));

    // Illegal command code.
    waitReady(1'b0, ok);
    app_en   = 1'b1;
    app_cmd  = 3'd3;
    app_addr = 29'd0;
    @(posedge ui_clk);
    #1 idleInputs();
    @(negedge ui_clk);
    checkOutput("err_bad_cmd", 256'(proto_err), 256'(1));

    // Write command with no data beat must leave the RAM untouched.
    waitReady(1'b0, ok);
    app_en       = 1'b1;
    app_cmd      = 3'd0;
    app_addr     = 29'd8;
    app_wdf_data = {256{1'b1}};
    @(posedge ui_clk);
    #1 idleInputs();
    v = '{1'b0, 29'd8, '0, pat(1)};
    applyStimulus(v);
    repeat (RD_LAT + 4) @(negedge ui_clk);
    checkOutput("err_sticky", 256'(proto_err), 256'(1));

    // Reset while a read is in flight: no valid may appear afterwards.
    v = '{1'b0, 29'd16, '0, pat(2)};
    applyStimulus(v);
    repeat (3) @(negedge ui_clk);
    rst_n = 1'b0;
    sb.delete();
    #1;
    checkOutput("midrst_proto_err", 256'(proto_err), 256'(0));
    checkOutput("midrst_valid", 256'(app_rd_data_valid), 256'(0));
    checkOutput("midrst_app_rdy", 256'(app_rdy), 256'(0));
    checkOutput("midrst_calib", 256'(init_calib_complete), 256'(0));
    repeat (2) @(negedge ui_clk);
    rst_n = 1'b1;
    n = 0;
    while (!init_calib_complete && n < 400) begin @(negedge ui_clk); n++; end
    checkOutput("recalib_len", 256'(n), 256'(200));
    checkOutput("recalib_no_err", 256'(proto_err), 256'(0));

    // Misaligned read: low bits dropped, data still returned, error flagged.
    v = '{1'b0, 29'd21, '0, pat(2)};
    applyStimulus(v);
    @(negedge ui_clk);
    checkOutput("err_misaligned", 256'(proto_err), 256'(1));
    repeat (RD_LAT + 4) @(negedge ui_clk);
    checkOutput("final_drain", 256'(sb.size()), 256'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
